// File: rtl/booth_radix4_seq_mul_pkg.sv
// Shared widths and FSM state encodings for the
// sequential radix-4 Booth multiplier.
package booth_radix4_seq_mul_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int DIGITS = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_radix4_seq_mul_enc.sv
// One radix-4 Booth encoder row: selects 0, +-a or +-2a
// as a one's-complement value plus a +1 correction bit.
module booth_radix4_enc
   import booth_radix4_seq_mul_pkg::*;
(
   input  logic [OP_W-1:0] data_i,
   input  logic [2:0]      triplet_i,
   output logic [OP_W:0]   res,
   output logic            sign
);

   logic [OP_W:0] mag;

   always_comb begin
      mag = '0;
      case (triplet_i)
         3'b001, 3'b010,
         3'b101, 3'b110: mag = {data_i[OP_W-1], data_i};
         3'b011, 3'b100: mag = {data_i, 1'b0};
         default:        mag = '0;
      endcase
      sign = triplet_i[2];
      res  = sign ? ~mag : mag;
   end

endmodule

// File: rtl/booth_radix4_seq_mul.sv
// Iterative signed 8x8 multiplier retiring one radix-4 Booth
// digit per cycle through a single shared encoder row.
module booth_radix4_seq_mul
   import booth_radix4_seq_mul_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              valid_i,
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [PROD_W-1:0] res_o,
   input  logic              ready_i,
   output logic              busy_o
);

   logic [1:0]        state_q;
   logic [1:0]        k_q;
   logic [OP_W-1:0]   a_q;
   logic [OP_W-1:0]   b_q;
   logic [PROD_W-1:0] acc_q;
   logic [PROD_W-1:0] res_q;

   logic [OP_W:0]     b_ext;
   logic [2:0]        triplet;
   logic [OP_W:0]     enc_res;
   logic              enc_sign;
   logic [PROD_W-1:0] pp;
   logic [PROD_W-1:0] acc_nxt;
   logic [OP_W-1:0]   b_rest;
   logic              rest_zero;
   logic              last;

   assign b_ext   = {b_q, 1'b0};
   assign triplet = b_ext[{k_q, 1'b0} +: 3];

   booth_radix4_enc u_enc (
      .data_i    (a_q),
      .triplet_i (triplet),
      .res       (enc_res),
      .sign      (enc_sign)
   );

   assign pp = {{(PROD_W-OP_W-1){enc_res[OP_W]}}, enc_res}
             + {{(PROD_W-1){1'b0}}, enc_sign};
   assign acc_nxt = acc_q + (pp << {k_q, 1'b0});

   // Upper digits are all zero when b[7:2k+1] is a pure sign run.
   assign b_rest    = OP_W'($signed(b_q) >>> {k_q, 1'b1});
   assign rest_zero = (b_rest == '0) || (b_rest == '1);
   assign last      = (k_q == 2'(DIGITS-1))
                    || (EARLY_TERM && rest_zero);

   assign ready_o = (state_q == ST_IDLE);
   assign busy_o  = (state_q == ST_BUSY);
   assign valid_o = (state_q == ST_DONE);
   assign res_o   = res_q;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  acc_q   <= '0;
                  k_q     <= '0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               acc_q <= acc_nxt;
               if (last) begin
                  res_q   <= acc_nxt;
                  state_q <= ST_DONE;
               end else begin
                  k_q <= k_q + 2'd1;
               end
            end
            ST_DONE: begin
               if (ready_i)
                  state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Directed bench for the sequential Booth multiplier, covering
// latency, early finish, stall, back-to-back and reset abort.
module tb_booth_radix4_seq_mul;

   logic        clk = 1'b0;
   logic        nreset;
   logic        valid1, valid0;
   logic [7:0]  a_i, b_i;
   logic        ready_i;
   logic        ready1, vout1, busy1;
   logic        ready0, vout0, busy0;
   logic [15:0] res1, res0;
   logic        sel;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   booth_radix4_seq_mul #(.EARLY_TERM(1'b1)) dut1 (
      .clk(clk), .nreset(nreset), .valid_i(valid1),
      .a_i(a_i), .b_i(b_i), .ready_o(ready1), .valid_o(vout1),
      .res_o(res1), .ready_i(ready_i), .busy_o(busy1)
   );

   booth_radix4_seq_mul #(.EARLY_TERM(1'b0)) dut0 (
      .clk(clk), .nreset(nreset), .valid_i(valid0),
      .a_i(a_i), .b_i(b_i), .ready_o(ready0), .valid_o(vout0),
      .res_o(res0), .ready_i(ready_i), .busy_o(busy0)
   );

   logic        c_ready, c_valid, c_busy;
   logic [15:0] c_res;
   assign c_ready = sel ? ready0 : ready1;
   assign c_valid = sel ? vout0  : vout1;
   assign c_busy  = sel ? busy0  : busy1;
   assign c_res   = sel ? res0   : res1;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      int          iters;
      logic [15:0] prod;
      int          stall;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input int iters, input logic [15:0] prod,
                        input int stall, input string nm);
      int  cnt;
      bit  got;
      cnt = 0;
      while (!c_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      a_i = a;
      b_i = b;
      if (sel) valid0 = 1'b1;
      else     valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid0 = 1'b0;
      valid1 = 1'b0;
      a_i = 8'hA5;
      b_i = 8'h5A;
      cnt = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         got = c_valid;
      end
      chk({nm, " iters"}, got ? cnt : -1, iters);
      chk({nm, " res"}, {16'd0, c_res}, {16'd0, prod});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({nm, " stall"}, {15'd0, c_valid, c_res},
             {15'd0, 1'b1, prod});
      end
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_i = 1'b0;
      chk({nm, " post"}, {14'd0, c_ready, c_valid, c_res},
          {14'd0, 1'b1, 1'b0, prod});
   endtask

   initial begin
      vecs[0] = '{8'd5,   8'd0,   1, 16'h0000, 0};
      vecs[1] = '{8'd7,   8'd3,   2, 16'd21,   0};
      vecs[2] = '{8'h80,  8'h80,  4, 16'h4000, 0};
      vecs[3] = '{8'h80,  8'h7F,  4, 16'hC080, 0};
      vecs[4] = '{8'hFF,  8'h80,  4, 16'h0080, 0};
      vecs[5] = '{8'h7F,  8'hFE,  1, 16'hFF02, 0};
      vecs[6] = '{8'd3,   8'h0C,  3, 16'd36,   0};
      vecs[7] = '{8'hFD,  8'hF9,  2, 16'd21,   5};

      sel = 1'b0;
      nreset = 1'b0;
      valid1 = 1'b0;
      valid0 = 1'b0;
      a_i = '0;
      b_i = '0;
      ready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset et1", {ready1, vout1, busy1, res1},
          {1'b1, 1'b0, 1'b0, 16'h0000});
      chk("reset et0", {ready0, vout0, busy0, res0},
          {1'b1, 1'b0, 1'b0, 16'h0000});
      nreset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].iters,
               vecs[i].prod, vecs[i].stall, $sformatf("vec%0d", i));

      // back-to-back: accept one edge after the transfer above
      do_op(8'd2, 8'hFF, 1, 16'hFFFE, 0, "b2b");

      sel = 1'b1;
      do_op(8'd5, 8'd0, 4, 16'h0000, 0, "et0 zero");
      do_op(8'd7, 8'd3, 4, 16'd21, 0, "et0 7x3");
      sel = 1'b0;

      // reset while busy
      a_i = 8'd100;
      b_i = 8'h9C;
      valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid1 = 1'b0;
      chk("abort busy", {31'd0, busy1}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      nreset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;
      chk("abort state", {ready1, vout1, busy1, res1},
          {1'b1, 1'b0, 1'b0, 16'h0000});
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vout1 || busy1) seen++;
         end
         chk("abort quiet", seen, 0);
      end
      do_op(8'd1, 8'd1, 1, 16'h0001, 0, "after abort");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
